// File: rtl/ntt_butterfly_addsub_pkg.sv
// Shared widths and latencies for the NTT butterfly datapath.
package ntt_butterfly_addsub_pkg;

    localparam int unsigned DATA_SIZE_ARB = 64;
    localparam int unsigned L_SIZE        = 2;
    localparam int unsigned MUL_LAT       = 2;
    // Multiplier depth + reducer stages + reducer output register.
    localparam int unsigned MR_LAT_DEF    = MUL_LAT + L_SIZE + 1;

    typedef enum logic [0:0] {
        OpCt,
        OpGs
    } mod_add_sub_op_e;

endpackage

// File: rtl/ntt_butterfly_addsub_mod_add_sub_half.sv
// Combinational modular add/sub pair with optional halving mod q.
module ntt_butterfly_addsub_mod_add_sub_half
    import ntt_butterfly_addsub_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_SIZE_ARB
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic              half_i,
    output logic [DATA_W-1:0] e_o,
    output logic [DATA_W-1:0] o_o
);

    // x/2 mod q for odd q: odd x is made even by adding q first.
    function automatic logic [DATA_W-1:0] halve(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] m);
        logic [DATA_W:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return DATA_W'(t >> 1);
    endfunction

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] sum_sub_q;
    logic              sum_borrow;
    logic [DATA_W-1:0] dif;
    logic              dif_borrow;
    logic [DATA_W-1:0] e_full;
    logic [DATA_W-1:0] o_full;

    always_comb begin
        sum                      = {1'b0, a_i} + {1'b0, c_i};
        // sum < 2q < 2^DATA_W, so a DATA_W+1 wide subtract leaves the borrow in the MSB.
        {sum_borrow, sum_sub_q}  = sum - {1'b0, q_i};
        e_full                   = sum_borrow ? sum[DATA_W-1:0] : sum_sub_q;
        {dif_borrow, dif}        = {1'b0, a_i} - {1'b0, c_i};
        o_full                   = dif_borrow ? (dif + q_i) : dif;
        e_o                      = half_i ? halve(e_full, q_i) : e_full;
        o_o                      = half_i ? halve(o_full, q_i) : o_full;
    end

endmodule

// File: rtl/ntt_butterfly_addsub.sv
// Butterfly add/sub stage: delays A to meet the reduced product C, registers E/O pair.
module ntt_butterfly_addsub
    import ntt_butterfly_addsub_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_SIZE_ARB,
    parameter int unsigned MR_LAT = MR_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] a_in,
    input  logic              half_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] c_in,
    output logic [DATA_W-1:0] e_out,
    output logic [DATA_W-1:0] o_out,
    output logic              out_valid
);

    if (MR_LAT < 1) begin : g_bad_lat
        $error("MR_LAT must be at least 1");
    end

    logic [DATA_W-1:0] a_q [MR_LAT];
    logic [DATA_W-1:0] a_d [MR_LAT];
    logic [MR_LAT-1:0] half_q, half_d;
    logic [MR_LAT-1:0] vld_q, vld_d;

    logic [DATA_W-1:0] e_q, e_d;
    logic [DATA_W-1:0] o_q, o_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] e_comb, o_comb;

    always_comb begin
        a_d[0]    = a_in;
        half_d[0] = half_in;
        vld_d[0]  = in_valid;
        for (int i = 1; i < MR_LAT; i++) begin
            a_d[i]    = a_q[i-1];
            half_d[i] = half_q[i-1];
            vld_d[i]  = vld_q[i-1];
        end
    end

    ntt_butterfly_addsub_mod_add_sub_half #(
        .DATA_W (DATA_W)
    ) u_mod_add_sub_half (
        .a_i    (a_q[MR_LAT-1]),
        .c_i    (c_in),
        .q_i    (q),
        .half_i (half_q[MR_LAT-1]),
        .e_o    (e_comb),
        .o_o    (o_comb)
    );

    // Outputs hold their last value on idle cycles.
    always_comb begin
        valid_d = vld_q[MR_LAT-1];
        e_d     = valid_d ? e_comb : e_q;
        o_d     = valid_d ? o_comb : o_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MR_LAT; i++) begin
                a_q[i] <= '0;
            end
            half_q  <= '0;
            vld_q   <= '0;
            e_q     <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            half_q  <= half_d;
            vld_q   <= vld_d;
            e_q     <= e_d;
            o_q     <= o_d;
            valid_q <= valid_d;
        end
    end

    assign e_out     = e_q;
    assign o_out     = o_q;
    assign out_valid = valid_q;

endmodule
